inv_arbiter: RTL and testbench

Round-robin controller that shares the single 64-bit modular-inverse unit (`ALU_INV`) between up to `N_REQ` point-arithmetic requesters (point add, point double, affine conversion). It accepts one operand at a time over a valid/ready handshake, launches the inverter with a one-cycle `enable` pulse, and waits for `inv_done`. It then returns the result to the owning requester. Zero operands and inverter hangs are handled locally with an error flag, so no requester can stall the shared unit.

---
 rtl/ecc_pkg.sv | 6 +
 rtl/rr_pick.sv | 26 ++
 rtl/inv_arbiter.sv | 112 +++++++++++
 tb/tb_inv_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared widths, inverter timeout and FSM state encoding for the ECC datapath arbiters
package ecc_pkg;
  localparam int ECC_WIDTH = 64;
  localparam int INV_TIMEOUT = 4096;
  typedef enum logic [2:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP, ST_RECOVER} inv_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin one-hot picker, searching from ptr+1 and wrapping
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  int j;
  // Scan from the farthest candidate back to ptr+1 so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx = '0;
    j = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/inv_arbiter.sv
// inv_arbiter: round-robin sharing of one modular-inverse unit with zero-operand and timeout handling
module inv_arbiter
  import ecc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = ECC_WIDTH,
  parameter int TIMEOUT = INV_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_operand,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   inv_enable,
  output logic [WIDTH-1:0]       inv_t,
  output logic                   inv_rst_n,
  input  logic [WIDTH-1:0]       inv_result,
  input  logic                   inv_done
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;
  inv_state_t state_q, state_d;
  logic [IW-1:0] g_q, g_d, ptr_q, ptr_d, pick_idx;
  logic [N_REQ-1:0] pick_grant;
  logic [WIDTH-1:0] op_q, op_d, data_q, data_d, pick_op;
  logic err_q, err_d, rstn_q, rstn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(pick_grant),
    .idx  (pick_idx)
  );
  always_comb begin
    pick_op = '0;
    for (int i = 0; i < N_REQ; i++) pick_op = pick_grant[i] ? req_operand[i*WIDTH +: WIDTH] : pick_op;
  end
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    ptr_d = ptr_q;
    op_d = op_q;
    data_d = data_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (|pick_grant) begin
        g_d = pick_idx;
        op_d = pick_op;
        data_d = '0;
        err_d = pick_op == '0;
        state_d = (pick_op == '0) ? ST_RESP : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        cnt_d = '0;
        state_d = ST_WAIT;
      end
      // A done arriving on the expiry cycle still delivers its result.
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (inv_done) begin
          data_d = inv_result;
          err_d = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_d == CW'(TIMEOUT - 1)) begin
          data_d = '0;
          err_d = 1'b1;
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: state_d = ST_RESP;
      ST_RESP: if (rsp_ready[g_q]) begin
        ptr_d = g_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rstn_d = state_d != ST_RECOVER;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q <= '0;
      ptr_q <= IW'(N_REQ - 1);
      op_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      rstn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      ptr_q <= ptr_d;
      op_q <= op_d;
      data_q <= data_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      rstn_q <= rstn_d;
    end
  end
  assign req_ready = (state_q == ST_IDLE) ? pick_grant : '0;
  assign rsp_valid = (state_q == ST_RESP) ? N_REQ'(1) << g_q : '0;
  assign inv_enable = state_q == ST_LAUNCH;
  assign inv_t = op_q;
  assign rsp_data = data_q;
  assign rsp_err = err_q;
  assign inv_rst_n = rstn_q;
endmodule

// File: tb/tb_inv_arbiter.sv
// tb_inv_arbiter: directed table plus corner sequences against a latency-programmable stub inverter
module tb_inv_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_operand = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [N-1:0] rsp_ready = '0;
  logic [W-1:0] rsp_data, inv_t, inv_result;
  logic rsp_err, inv_enable, inv_rst_n, inv_done;
  logic stub_done = 1'b0;
  logic inject = 1'b0;
  int cyc = 0;
  int due = -1;
  int lat_cfg = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Stub inverter: done lat_cfg cycles after enable (lat_cfg 0 = hang), result ~t, cleared by its reset.
  always @(negedge clk) begin
    if (inv_rst_n !== 1'b1) due = -1;
    else if (inv_enable && lat_cfg > 0) due = cyc + lat_cfg;
    stub_done = (due >= 0) && (cyc == due);
  end
  assign inv_done = stub_done | inject;
  assign inv_result = inject ? 64'hDEAD_BEEF_0BAD_F00D : ~inv_t;
  inv_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_operand(req_operand),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .inv_enable(inv_enable), .inv_t(inv_t),
    .inv_rst_n(inv_rst_n), .inv_result(inv_result), .inv_done(inv_done)
  );
  typedef struct {
    int r;
    logic [63:0] op;
    int lat;
    int d;
    logic [63:0] data;
    logic err;
    int en;
    int rl_at;
  } vec_t;
  vec_t tbl[6];
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic wait_acc(output int r);
    r = -1;
    for (int n = 0; n < 20; n++) begin
      if (|(req_ready & req_valid)) break;
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) r = i;
  endtask
  task automatic send(input string name, input int r, input logic [63:0] op);
    int g;
    req_valid = '0;
    req_operand[r*W +: W] = op;
    req_valid[r] = 1'b1;
    #1;
    wait_acc(g);
    check({name, "_grant"}, 64'(req_ready), 64'(1) << r);
  endtask
  task automatic wait_rsp(input string name, input int r, input logic [63:0] op, input bit drop,
                          output int d, output int en, output int rl_at, output int rl_cnt);
    d = 0;
    en = 0;
    rl_at = 0;
    rl_cnt = 0;
    while (d < 100) begin
      @(negedge clk);
      d++;
      if (drop) req_valid[r] = 1'b0;
      if (inv_enable) begin
        en++;
        check({name, "_inv_t"}, inv_t, op);
      end
      if (!inv_rst_n) begin
        rl_cnt++;
        if (rl_at == 0) rl_at = d;
      end
      if (rsp_valid != '0) break;
    end
    check({name, "_rsp_valid"}, 64'(rsp_valid), 64'(1) << r);
  endtask
  task automatic ack(input string name, input int r);
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    check({name, "_rsp_clear"}, 64'(rsp_valid), 64'h0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d, en, rl_at, rl_cnt, g;
    string nm;
    tbl[0] = '{1, 64'h5, 10, 12, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1, 0};
    tbl[1] = '{2, 64'h0, 10, 1, 64'h0, 1'b1, 0, 0};
    tbl[2] = '{0, 64'h7, 0, 18, 64'h0, 1'b1, 1, 17};
    tbl[3] = '{3, 64'h8000_0000_0000_0000, 1, 3, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1, 0};
    tbl[4] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 15, 17, 64'h0, 1'b0, 1, 0};
    tbl[5] = '{1, 64'h9, 16, 18, 64'h0, 1'b1, 1, 17};
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_data", rsp_data, 64'h0);
    check("rst_rsp_err", 64'(rsp_err), 64'h0);
    check("rst_inv_enable", 64'(inv_enable), 64'h0);
    check("rst_inv_t", inv_t, 64'h0);
    check("rst_inv_rst_n", 64'(inv_rst_n), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_inv_rst_n", 64'(inv_rst_n), 64'h1);
    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("v%0d", i);
      lat_cfg = tbl[i].lat;
      send(nm, tbl[i].r, tbl[i].op);
      wait_rsp(nm, tbl[i].r, tbl[i].op, 1'b1, d, en, rl_at, rl_cnt);
      check({nm, "_latency"}, 64'(d), 64'(tbl[i].d));
      check({nm, "_rsp_data"}, rsp_data, tbl[i].data);
      check({nm, "_rsp_err"}, 64'(rsp_err), 64'(tbl[i].err));
      check({nm, "_enables"}, 64'(en), 64'(tbl[i].en));
      check({nm, "_inv_rst_at"}, 64'(rl_at), 64'(tbl[i].rl_at));
      check({nm, "_inv_rst_len"}, 64'(rl_cnt), (tbl[i].rl_at != 0) ? 64'h1 : 64'h0);
      ack(nm, tbl[i].r);
    end
    lat_cfg = 10;
    send("midrst", 1, 64'h5);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("midrst_rsp_data", rsp_data, 64'h0);
    check("midrst_rsp_err", 64'(rsp_err), 64'h0);
    check("midrst_inv_enable", 64'(inv_enable), 64'h0);
    check("midrst_inv_t", inv_t, 64'h0);
    check("midrst_inv_rst_n", 64'(inv_rst_n), 64'h0);
    @(negedge clk);
    check("midrst_inv_rst_n_release", 64'(inv_rst_n), 64'h1);
    lat_cfg = 3;
    for (int i = 0; i < N; i++) req_operand[i*W +: W] = 64'(i + 1);
    req_valid = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      nm = $sformatf("rr%0d", k);
      wait_acc(g);
      check({nm, "_grant"}, 64'(req_ready), 64'(1) << (k % N));
      wait_rsp(nm, k % N, 64'(k % N + 1), 1'b0, d, en, rl_at, rl_cnt);
      check({nm, "_rsp_data"}, rsp_data, ~64'(k % N + 1));
      check({nm, "_rsp_err"}, 64'(rsp_err), 64'h0);
      ack(nm, k % N);
    end
    req_valid = '0;
    lat_cfg = 2;
    send("bp", 3, 64'h1234);
    wait_rsp("bp", 3, 64'h1234, 1'b1, d, en, rl_at, rl_cnt);
    check("bp_latency", 64'(d), 64'd4);
    req_valid = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      inject = (i == 5) || (i == 12);
      @(negedge clk);
      nm = $sformatf("bp%0d", i);
      check({nm, "_rsp_valid"}, 64'(rsp_valid), 64'h8);
      check({nm, "_rsp_data"}, rsp_data, 64'hFFFF_FFFF_FFFF_EDCB);
      check({nm, "_rsp_err"}, 64'(rsp_err), 64'h0);
      check({nm, "_req_ready"}, 64'(req_ready), 64'h0);
    end
    inject = 1'b0;
    req_valid = '0;
    ack("bp", 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
